// File: rtl/matrix_operand_loader_pkg.sv
// Shared types and constants for the matrix operand loader: controller states,
// frame geometry and the element-to-operand index map.
package matrix_operand_loader_pkg;

    localparam int unsigned NUM_ELEM = 8;
    localparam int unsigned IDX_W    = 3;

    localparam logic [IDX_W-1:0] IdxA00 = 3'd0;
    localparam logic [IDX_W-1:0] IdxA01 = 3'd1;
    localparam logic [IDX_W-1:0] IdxA10 = 3'd2;
    localparam logic [IDX_W-1:0] IdxA11 = 3'd3;
    localparam logic [IDX_W-1:0] IdxB00 = 3'd4;
    localparam logic [IDX_W-1:0] IdxB01 = 3'd5;
    localparam logic [IDX_W-1:0] IdxB10 = 3'd6;
    localparam logic [IDX_W-1:0] IdxB11 = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitDone,
        StRelease
    } ctrl_state_e;

endpackage

// File: rtl/matrix_operand_loader_if.sv
// Valid/ready operand stream feeding the loader; master is the producer.
interface matrix_operand_loader_if #(
    parameter int unsigned DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/matrix_operand_loader_stager.sv
// Staging bank: collects one eight-element frame, checks its length and raises
// pend once a well-formed frame is complete.
module matrix_operand_loader_stager
    import matrix_operand_loader_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             accept_i,
    input  logic [DATA_W-1:0]                data_i,
    input  logic                             last_i,
    input  logic                             launch_i,
    output logic                             pend_o,
    output logic                             len_err_o,
    output logic [NUM_ELEM-1:0][DATA_W-1:0]  stage_o
);

    logic [IDX_W-1:0]                idx_q;
    logic                            pend_q;
    logic [NUM_ELEM-1:0][DATA_W-1:0] stage_q;

    // A frame is well formed only when in_last lands exactly on the eighth beat.
    assign len_err_o = accept_i && (last_i != (idx_q == IdxB11));
    assign pend_o    = pend_q;
    assign stage_o   = stage_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            pend_q  <= 1'b0;
            stage_q <= '0;
        end else begin
            if (launch_i) begin
                pend_q <= 1'b0;
            end
            if (accept_i) begin
                stage_q[idx_q] <= data_i;
                if (idx_q == IdxB11) begin
                    idx_q <= '0;
                    if (last_i) begin
                        pend_q <= 1'b1;
                    end
                end else if (last_i) begin
                    idx_q <= '0;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/matrix_operand_loader.sv
// Operand loader for the 2x2 matrix multiplier: launches staged frames, holds
// operands stable across the start/done handshake and tracks errors and completions.
module matrix_operand_loader
    import matrix_operand_loader_pkg::*;
#(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    matrix_operand_loader_if.slave in_if,
    output logic [DATA_W-1:0]    a00,
    output logic [DATA_W-1:0]    a01,
    output logic [DATA_W-1:0]    a10,
    output logic [DATA_W-1:0]    a11,
    output logic [DATA_W-1:0]    b00,
    output logic [DATA_W-1:0]    b01,
    output logic [DATA_W-1:0]    b10,
    output logic [DATA_W-1:0]    b11,
    output logic                 mm_start,
    input  logic                 mm_done,
    input  logic                 mm_busy,
    output logic                 loader_busy,
    output logic                 err_len,
    output logic                 err_timeout,
    input  logic                 clear_err,
    output logic [CNT_W-1:0]     frames_done
);

    localparam int unsigned     TmoW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    ctrl_state_e                     state_q;
    logic                            start_q;
    logic [NUM_ELEM-1:0][DATA_W-1:0] ops_q;
    logic [NUM_ELEM-1:0][DATA_W-1:0] stage;
    logic [TmoW-1:0]                 tmo_q;
    logic [CNT_W-1:0]                done_cnt_q;
    logic                            err_len_q;
    logic                            err_tmo_q;
    logic                            pend;
    logic                            len_err;
    logic                            accept;
    logic                            launch;
    logic                            tmo_hit;
    logic                            unused_mm_busy;

    // Sequencing relies solely on start/done.
    assign unused_mm_busy = mm_busy;

    assign in_if.in_ready = !pend && !rst;
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign launch         = (state_q == StIdle) && pend;
    assign tmo_hit        = (state_q == StWaitDone) && !mm_done && (tmo_q == TmoLast);

    matrix_operand_loader_stager #(
        .DATA_W (DATA_W)
    ) u_stager (
        .clk       (clk),
        .rst       (rst),
        .accept_i  (accept),
        .data_i    (in_if.in_data),
        .last_i    (in_if.in_last),
        .launch_i  (launch),
        .pend_o    (pend),
        .len_err_o (len_err),
        .stage_o   (stage)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            ops_q      <= '0;
            tmo_q      <= '0;
            done_cnt_q <= '0;
            err_len_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pend) begin
                        state_q <= StLaunch;
                        ops_q   <= stage;
                        start_q <= 1'b1;
                    end
                end
                StLaunch: begin
                    state_q <= StWaitDone;
                    tmo_q   <= '0;
                end
                StWaitDone: begin
                    if (mm_done) begin
                        state_q    <= StRelease;
                        start_q    <= 1'b0;
                        done_cnt_q <= done_cnt_q + CNT_W'(1);
                    end else if (tmo_hit) begin
                        state_q <= StRelease;
                        start_q <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                StRelease: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    start_q <= 1'b0;
                end
            endcase

            if (clear_err) begin
                err_len_q <= 1'b0;
                err_tmo_q <= 1'b0;
            end else begin
                if (len_err) begin
                    err_len_q <= 1'b1;
                end
                if (tmo_hit) begin
                    err_tmo_q <= 1'b1;
                end
            end
        end
    end

    assign a00         = ops_q[IdxA00];
    assign a01         = ops_q[IdxA01];
    assign a10         = ops_q[IdxA10];
    assign a11         = ops_q[IdxA11];
    assign b00         = ops_q[IdxB00];
    assign b01         = ops_q[IdxB01];
    assign b10         = ops_q[IdxB10];
    assign b11         = ops_q[IdxB11];
    assign mm_start    = start_q;
    assign loader_busy = pend || (state_q != StIdle);
    assign err_len     = err_len_q;
    assign err_timeout = err_tmo_q;
    assign frames_done = done_cnt_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Bench for matrix_operand_loader: directed and random frames against a
// frame-queue reference and a behavioural 2x2 multiplier.
module tb_matrix_operand_loader;

    localparam int unsigned DW  = 16;
    localparam int unsigned TMO = 64;
    localparam int unsigned CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] a00, a01, a10, a11, b00, b01, b10, b11;
    logic          mm_start, mm_done, mm_busy, loader_busy;
    logic          err_len, err_timeout, clear_err;
    logic [CW-1:0] frames_done;

    always #5 clk = ~clk;

    matrix_operand_loader_if #(.DATA_W(DW)) in_if ();

    matrix_operand_loader #(
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_if       (in_if),
        .a00         (a00),
        .a01         (a01),
        .a10         (a10),
        .a11         (a11),
        .b00         (b00),
        .b01         (b01),
        .b10         (b10),
        .b11         (b11),
        .mm_start    (mm_start),
        .mm_done     (mm_done),
        .mm_busy     (mm_busy),
        .loader_busy (loader_busy),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .clear_err   (clear_err),
        .frames_done (frames_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [127:0] dut_ops;
    assign dut_ops = {a00, a01, a10, a11, b00, b01, b10, b11};

    // Reference 2x2 product, element order a00..a11 then b00..b11.
    function automatic logic [127:0] ref_mul(input logic [127:0] f);
        int unsigned a[2][2];
        int unsigned b[2][2];
        int unsigned c;
        logic [127:0] r;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                a[i][j] = 32'(f[127-16*(2*i+j) -: 16]);
                b[i][j] = 32'(f[127-16*(4+2*i+j) -: 16]);
            end
        end
        r = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                c = 0;
                for (int k = 0; k < 2; k++) c += a[i][k] * b[k][j];
                r[127-32*(2*i+j) -: 32] = c;
            end
        end
        return r;
    endfunction

    // Multiplier model: level start, done held until start drops.
    logic [127:0] mdl_c;
    int           mdl_lat = 3;
    int           mdl_cnt;
    bit           mdl_busy, mdl_done_r, never_done = 1'b0;

    always @(posedge clk) begin
        if (rst || !mm_start) begin
            mdl_busy   <= 1'b0;
            mdl_done_r <= 1'b0;
        end else if (!mdl_busy && !mdl_done_r) begin
            mdl_busy <= 1'b1;
            mdl_cnt  <= mdl_lat;
            mdl_c    <= ref_mul(dut_ops);
        end else if (mdl_busy) begin
            if (mdl_cnt <= 1) begin
                mdl_busy <= 1'b0;
                if (!never_done) mdl_done_r <= 1'b1;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end
    end
    assign mm_done = mdl_done_r;
    assign mm_busy = mdl_busy;

    // Launch monitor: every launch consumes the oldest accepted frame.
    logic [127:0] exp_q[$];
    logic [127:0] cur_frame = '0;
    bit           prev_start = 1'b0, prev_done = 1'b0;
    int           launches = 0;

    always @(negedge clk) begin
        if (mm_start && !prev_start) begin
            launches++;
            chk("launch_expected", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) cur_frame = exp_q.pop_front();
            chk("launch_ops", dut_ops, cur_frame);
        end else if (mm_start) begin
            chk("frozen_ops", dut_ops, cur_frame);
        end
        if (mm_done && !prev_done) chk("result", mdl_c, ref_mul(cur_frame));
        prev_start = mm_start;
        prev_done  = mm_done;
    end

    task automatic beat(input logic [DW-1:0] d, input bit last, output bit first_ready);
        int n = 0;
        @(negedge clk);
        in_if.in_valid = 1'b1;
        in_if.in_data  = d;
        in_if.in_last  = last;
        first_ready    = in_if.in_ready;
        while (!in_if.in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 128'(n < 400), 128'd1);
        @(posedge clk);
        #1;
        in_if.in_valid = 1'b0;
        in_if.in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [127:0] f, input int len, input bit last_end,
                              input int gap_max);
        bit r;
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            beat((i < 8) ? f[127-16*i -: 16] : DW'($urandom), last_end && (i == len - 1), r);
        end
        if (len == 8 && last_end) exp_q.push_back(f);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (loader_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 128'(n < 1000), 128'd1);
    endtask

    task automatic wait_level(input string tag, input bit want_start);
        int n = 0;
        @(negedge clk);
        while (mm_start != want_start && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(n < 1000), 128'd1);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ops"}, dut_ops, 128'd0);
        chk({tag, "_flags"}, 128'({mm_start, loader_busy, err_len, err_timeout}), 128'd0);
        chk({tag, "_frames"}, 128'(frames_done), 128'd0);
    endtask

    function automatic logic [127:0] rand_frame();
        logic [127:0] f;
        for (int i = 0; i < 8; i++) f[127-16*i -: 16] = DW'($urandom_range(0, 65535));
        return f;
    endfunction

    initial begin
        int           exp_done = 0;
        int           l0, n, gap;
        bit           r;
        logic [127:0] f1, f2;

        rst            = 1'b1;
        clear_err      = 1'b0;
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        in_if.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        chk("reset_ready", 128'(in_if.in_ready), 128'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 128'(in_if.in_ready), 128'd1);

        // Basic frame 1..8 with latency and release checks.
        mdl_lat = 3;
        f1 = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        send_frame(f1, 8, 1'b1, 0);
        @(negedge clk);
        chk("lat_n_start", 128'(mm_start), 128'd0);
        chk("lat_n_busy", 128'(loader_busy), 128'd1);
        @(negedge clk);
        chk("lat_n1_start", 128'(mm_start), 128'd1);
        chk("lat_n1_ops", dut_ops, f1);
        n = 0;
        while (!mm_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("f1_result", mdl_c, {32'd19, 32'd22, 32'd43, 32'd50});
        wait_level("f1_drop", 1'b0);
        chk("release_busy", 128'(loader_busy), 128'd1);
        @(negedge clk);
        chk("idle_after_release", 128'({loader_busy, mm_start}), 128'd0);
        exp_done = 1;
        chk("frames_1", 128'(frames_done), 128'(exp_done));

        // Second frame staged while the first is still in flight.
        mdl_lat = 20;
        f1 = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        f2 = {16'd2, 16'd0, 16'd0, 16'd2, 16'd1, 16'd1, 16'd1, 16'd1};
        send_frame(f1, 8, 1'b1, 0);
        wait_level("f1b_start", 1'b1);
        for (int i = 0; i < 8; i++) begin
            beat(f2[127-16*i -: 16], i == 7, r);
            chk("overlap_ready", 128'(r), 128'd1);
        end
        exp_q.push_back(f2);
        @(negedge clk);
        chk("pend_ready_low", 128'(in_if.in_ready), 128'd0);
        chk("overlap_ops", dut_ops, f1);
        wait_level("f1b_drop", 1'b0);
        n = 1;
        @(negedge clk);
        while (!mm_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_gap", 128'(n), 128'd2);
        chk("f2_ops", dut_ops, f2);
        n = 0;
        while (!mm_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("f2_result", mdl_c, {32'd2, 32'd2, 32'd2, 32'd2});
        wait_idle();
        exp_done = 3;
        chk("frames_3", 128'(frames_done), 128'(exp_done));

        // Short frame, then a good one.
        mdl_lat = 2;
        l0 = launches;
        send_frame(rand_frame(), 5, 1'b1, 1);
        @(negedge clk);
        chk("short_err", 128'(err_len), 128'd1);
        repeat (4) @(negedge clk);
        chk("short_no_launch", 128'(launches), 128'(l0));
        send_frame({16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 16'd17, 16'd18}, 8, 1'b1, 1);
        wait_idle();
        exp_done++;
        chk("after_short_frames", 128'(frames_done), 128'(exp_done));
        chk("err_len_sticky", 128'(err_len), 128'd1);
        pulse_clear();
        chk("err_len_cleared", 128'(err_len), 128'd0);

        // clear_err wins over a same-cycle length error.
        @(negedge clk);
        clear_err = 1'b1;
        send_frame(rand_frame(), 2, 1'b1, 0);
        @(negedge clk);
        clear_err = 1'b0;
        chk("clear_priority", 128'(err_len), 128'd0);

        // Eight beats without in_last.
        send_frame(rand_frame(), 8, 1'b0, 0);
        @(negedge clk);
        chk("long_err", 128'(err_len), 128'd1);
        pulse_clear();

        // Done never arrives.
        never_done = 1'b1;
        send_frame(rand_frame(), 8, 1'b1, 0);
        wait_level("tmo_start", 1'b1);
        n = 1;
        @(negedge clk);
        while (mm_start && n < 500) begin
            chk("tmo_not_yet", 128'(err_timeout), 128'd0);
            @(negedge clk);
            n++;
        end
        chk("tmo_high_cycles", 128'(n), 128'(TMO + 1));
        chk("tmo_err", 128'(err_timeout), 128'd1);
        chk("tmo_frames", 128'(frames_done), 128'(exp_done));
        wait_idle();
        never_done = 1'b0;
        pulse_clear();
        chk("tmo_cleared", 128'(err_timeout), 128'd0);

        // Reset mid-frame.
        for (int i = 0; i < 3; i++) beat(DW'(i + 40), 1'b0, r);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rst_frame");
        rst = 1'b0;
        exp_done = 0;
        f1 = rand_frame();
        send_frame(f1, 8, 1'b1, 1);
        wait_idle();
        exp_done++;
        chk("rst_frame_fresh", 128'(frames_done), 128'(exp_done));
        chk("rst_frame_ops", dut_ops, f1);

        // Reset while waiting for done.
        mdl_lat = 30;
        send_frame(rand_frame(), 8, 1'b1, 0);
        wait_level("rstw_start", 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rst_wait");
        rst = 1'b0;
        exp_done = 0;
        mdl_lat = 4;
        send_frame(rand_frame(), 8, 1'b1, 1);
        wait_idle();
        exp_done++;
        chk("rst_wait_fresh", 128'(frames_done), 128'(exp_done));

        // Random mix of good and malformed frames.
        for (int it = 0; it < 40; it++) begin
            mdl_lat = $urandom_range(1, 8);
            gap = $urandom_range(0, 2);
            n = $urandom_range(0, 9);
            if (n == 0) begin
                send_frame(rand_frame(), $urandom_range(1, 7), 1'b1, gap);
                @(negedge clk);
                chk("rand_short_err", 128'(err_len), 128'd1);
                pulse_clear();
            end else if (n == 1) begin
                send_frame(rand_frame(), 8, 1'b0, gap);
                @(negedge clk);
                chk("rand_long_err", 128'(err_len), 128'd1);
                pulse_clear();
            end else begin
                send_frame(rand_frame(), 8, 1'b1, gap);
                exp_done++;
            end
            if ($urandom_range(0, 1) == 1) begin
                wait_idle();
                chk("rand_frames", 128'(frames_done), 128'(exp_done % (1 << CW)));
            end
        end
        wait_idle();
        chk("rand_final_frames", 128'(frames_done), 128'(exp_done % (1 << CW)));
        chk("rand_queue_empty", 128'(exp_q.size()), 128'd0);

        // Run the counter to its maximum and wrap.
        while (exp_done % (1 << CW) != (1 << CW) - 1) begin
            send_frame(rand_frame(), 8, 1'b1, 0);
            exp_done++;
        end
        wait_idle();
        chk("cnt_max", 128'(frames_done), 128'((1 << CW) - 1));
        send_frame(rand_frame(), 8, 1'b1, 0);
        wait_idle();
        chk("cnt_wrap", 128'(frames_done), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_operand_loader.md
Name: matrix_operand_loader

Overview:
- Upstream feeder for the 2x2 matrix multiplier. Receives a serial stream of eight 16-bit operands over a valid/ready interface and assembles them into one A/B operand frame.
- Presents the frame on parallel, stable outputs and drives the multiplier's level start/busy/done handshake.
- Double-buffered: a staging bank collects the next frame while the multiplier works on the current one. Length and timeout errors are flagged.

Parameters:
- DATA_W, 16, operand width; matches multiplier input width.
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT_DONE before abort; must be 1 or more.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  stream element valid.
- in_ready  out  1  loader can accept an element.
- in_data  in  DATA_W  element value.
- in_last  in  1  marks the final element of a frame.
- a00,a01,a10,a11,b00,b01,b10,b11  out  DATA_W each  registered operands to the multiplier.
- mm_start  out  1  level start to the multiplier.
- mm_done  in  1  multiplier done.
- mm_busy  in  1  multiplier busy.
- loader_busy  out  1  a frame is pending or in flight.
- err_len  out  1  sticky frame-length error.
- err_timeout  out  1  sticky done-timeout error.
- clear_err  in  1  clears both sticky errors.
- frames_done  out  CNT_W  count of completed multiplications; wraps.

Behaviour:
- Reset: synchronous, active-high. All outputs are 0, including operands, mm_start, errors and frames_done. Element index is 0, pend is 0, controller is IDLE. in_ready = !pend && !rst.
- Element order: index 0..7 maps to a00,a01,a10,a11,b00,b01,b10,b11.

Fill side:
- A beat is accepted when in_valid && in_ready. It writes staging[idx], then idx increments.
- in_last with idx<7: err_len is set, the frame is discarded, idx returns to 0.
- idx==7 without in_last: err_len is set, the frame is discarded, idx returns to 0.
- idx==7 with in_last: pend is set to 1 and idx returns to 0.
- in_ready is 0 while pend=1. There is no back-to-back write into a pending bank.

Controller FSM:
- IDLE -> LAUNCH when pend=1. On that edge, copy staging to the operand registers and clear pend.
- LAUNCH: mm_start=1 for one cycle, then go to WAIT_DONE. Clear the timeout counter.
- WAIT_DONE: hold mm_start=1 and increment the counter each cycle.
  - mm_done=1: go to RELEASE and increment frames_done.
  - Counter reaches TIMEOUT_CYCLES with no done: set err_timeout, go to RELEASE, frames_done unchanged.
- RELEASE: mm_start=0 for exactly 1 cycle, then IDLE. This guarantees the multiplier sees start low and returns to its idle state.

Timing and boundary rules:
- Latency: last beat accepted at edge N -> operands valid and mm_start=1 after edge N+1.
- Operands stay frozen from LAUNCH through RELEASE. The staging bank may refill in parallel.
- Launch/fill same cycle: pend is cleared by the controller at the same edge where in_ready was already 0. No conflict.
- loader_busy = pend || (state != IDLE).
- clear_err has priority over a same-cycle error set; the error is cleared.
- mm_busy is advisory only; it is ignored for sequencing.
- rst mid-frame or mid-wait: the partial frame is dropped, mm_start drops the following cycle, and the counters clear.
- frames_done wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package (e.g. mgpu_pkg): controller state enum (IDLE, LAUNCH, WAIT_DONE, RELEASE), localparam NUM_ELEM=8, element index constants.
- Optional sub-module: operand_stager, holding the staging bank, index counter, length check and pend flag. The top level holds the controller FSM, operand registers and counters.

Test Plan:
- Stream 1,2,3,4,5,6,7,8 with in_last on beat 8, multiplier model attached. Required: a00..b11 = 1..8; mm_start high from edge N+1; the model returns C = 19,22,43,50; frames_done = 1; RELEASE low for 1 cycle.
- Send a second frame 2,0,0,2,1,1,1,1 during WAIT_DONE of the first. Required: in_ready stays 1 until beat 8, then 0. Operands unchanged until the next LAUNCH. The second result is C = 2,2,2,2.
- Assert in_last on beat 5. Required: err_len=1, no mm_start, idx returns to 0. A following valid frame completes normally.
- Hold mm_done=0. Required: err_timeout=1 after TIMEOUT_CYCLES (64) cycles in WAIT_DONE, mm_start drops, frames_done unchanged. clear_err returns err_timeout to 0.
- Apply rst after beat 3, and separately in WAIT_DONE. Required: all outputs 0 the next cycle, and a fresh frame processes correctly.
- Preload frames_done to 0xFFFF by running the counter there. Required: it wraps to 0x0000 on the next completion.
